// File: rtl/i2cs_pkg.sv
// ---------------------------------------------------------------------------
// i2cs_pkg
// Shared definitions for the I2C slave engines.
//   i2cs_rx_state_t : receive FSM state encoding (3 bits)
//   I2CS_ADDR_W     : slave address width (7)
//   I2CS_BYTE_W     : data byte width (8)
//   I2CS_RW_WRITE   : value of the R/W bit for a master-write transfer
// ---------------------------------------------------------------------------
package i2cs_pkg;

    localparam int   I2CS_ADDR_W   = 7;
    localparam int   I2CS_BYTE_W   = 8;
    localparam logic I2CS_RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } i2cs_rx_state_t;

endpackage

// File: rtl/i2cs_pin_sync.sv
// ---------------------------------------------------------------------------
// i2cs_pin_sync
// Brings raw SCL/SDA pad inputs into the clk domain and derives bus events.
// Optional glitch filter enabled by defining I2CS_RX_GLITCH_FILTER_EN.
//
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   scl_i      : raw SCL pad input
//   sda_i      : raw SDA pad input
//   sda        : synchronised (and filtered) SDA level
//   scl_rise   : one-cycle strobe, SCL went 0->1
//   scl_fall   : one-cycle strobe, SCL went 1->0
//   start_det  : one-cycle strobe, SDA fell while SCL high
//   stop_det   : one-cycle strobe, SDA rose while SCL high
// ---------------------------------------------------------------------------
module i2cs_pin_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || FILT_LEN < 2) begin : g_param_check
        $error("i2cs_pin_sync: SYNC_STAGES must be 2..3 and FILT_LEN >= 2");
    end

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_f;
    logic                   sda_f;
    logic                   scl_d;
    logic                   sda_d;

    // Preset to 1 so an idle (pulled-up) bus produces no spurious edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2CS_RX_GLITCH_FILTER_EN
    // The filtered level only follows the input once the last FILT_LEN
    // samples all agree; anything shorter is treated as a glitch.
    logic [FILT_LEN-1:0] scl_hist;
    logic [FILT_LEN-1:0] sda_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[FILT_LEN-2:0], scl_s};
            sda_hist <= {sda_hist[FILT_LEN-2:0], sda_s};
            if (&scl_hist) begin
                scl_f <= 1'b1;
            end else if (~|scl_hist) begin
                scl_f <= 1'b0;
            end
            if (&sda_hist) begin
                sda_f <= 1'b1;
            end else if (~|sda_hist) begin
                sda_f <= 1'b0;
            end
        end
    end
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign sda       = sda_f;
    assign scl_rise  =  scl_f & ~scl_d;
    assign scl_fall  = ~scl_f &  scl_d;
    // SCL must be high both before and after the SDA transition.
    assign start_det = scl_f & scl_d &  sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d &  sda_f;

endmodule

// File: rtl/i2cs_rx_byte_engine.sv
// ---------------------------------------------------------------------------
// i2cs_rx_byte_engine
// I2C slave receive front end feeding a 256x8 synchronous RX FIFO.
// Matches the own 7-bit address on master-write transfers, deserialises data
// bytes, pushes each complete byte and ACKs it (NACK when the FIFO is full).
// Optional SCL/SDA glitch filter: define I2CS_RX_GLITCH_FILTER_EN.
//
// Ports:
//   clk, rst        : system clock, asynchronous active-high reset
//   enable_i        : 0 forces IDLE and releases SDA
//   slave_addr_i    : own 7-bit address (quasi-static)
//   scl_i, sda_i    : raw pad inputs
//   sda_oe_o        : 1 = pull SDA low
//   fifo_push_o     : one-cycle push strobe
//   fifo_wr_data_o  : byte presented with the push
//   fifo_full_i     : FIFO full flag
//   busy_o          : addressed transfer in progress
//   overflow_o      : sticky, a byte was dropped because the FIFO was full
//   overflow_clr_i  : clears overflow_o (a same-cycle set wins)
//   dbg_state_o     : current FSM state (i2cs_rx_state_t encoding)
//
// Handshake: fifo_push_o is a single-cycle strobe with fifo_wr_data_o valid in
// the same cycle; it is only ever raised in a cycle where fifo_full_i is 0.
// ---------------------------------------------------------------------------
module i2cs_rx_byte_engine
    import i2cs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic [I2CS_ADDR_W-1:0] slave_addr_i,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic                   sda_oe_o,
    output logic                   fifo_push_o,
    output logic [I2CS_BYTE_W-1:0] fifo_wr_data_o,
    input  logic                   fifo_full_i,
    output logic                   busy_o,
    output logic                   overflow_o,
    input  logic                   overflow_clr_i,
    output logic [2:0]             dbg_state_o
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2cs_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_pin_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2cs_rx_state_t         state_q, state_d;
    logic [I2CS_BYTE_W-1:0] shift_q, shift_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    // drive_q: inside an ACK slot, set on the first SCL fall and cleared on
    // the second; it marks the window in which SDA may be pulled low.
    logic                   drive_q, drive_d;
    logic                   ack_pend_q, ack_pend_d;
    logic                   overflow_q;
    logic                   byte_done;
    logic                   overflow_set;

    // A full byte sits in shift_q for exactly the one cycle after the 8th sample.
    assign byte_done = (bit_cnt_q == 4'd8);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            drive_q    <= 1'b0;
            ack_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            drive_q    <= drive_d;
            ack_pend_q <= ack_pend_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        drive_d    = drive_q;
        ack_pend_d = ack_pend_q;

        unique case (state_q)
            ST_IDLE: begin
            end
            ST_ADDR: begin
                if (byte_done) begin
                    drive_d   = 1'b0;
                    bit_cnt_d = '0;
                    if (shift_q[7:1] == slave_addr_i && shift_q[0] == I2CS_RW_WRITE) begin
                        state_d = ST_ADDR_ACK;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end else if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            ST_DATA: begin
                if (byte_done) begin
                    ack_pend_d = ~fifo_full_i;
                    drive_d    = 1'b0;
                    state_d    = ST_DATA_ACK;
                end else if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
                // Both ACK slots walk the same two SCL falls; only whether SDA
                // is actually pulled low differs (see output logic).
                if (scl_fall) begin
                    if (!drive_q) begin
                        drive_d = 1'b1;
                    end else begin
                        drive_d   = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_IGNORE: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus conditions and disable override whatever the state was doing;
        // a partially shifted byte is simply abandoned.
        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            shift_d   = '0;
            drive_d   = 1'b0;
        end
        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            drive_d   = 1'b0;
        end
        if (!enable_i) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            drive_d   = 1'b0;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        fifo_push_o    = 1'b0;
        overflow_set   = 1'b0;
        fifo_wr_data_o = shift_q;
        sda_oe_o       = 1'b0;
        busy_o         = 1'b0;

        if (state_q == ST_DATA && byte_done && enable_i && !start_det && !stop_det) begin
            fifo_push_o  = ~fifo_full_i;
            overflow_set =  fifo_full_i;
        end

        if (drive_q) begin
            sda_oe_o = (state_q == ST_ADDR_ACK) || (state_q == ST_DATA_ACK && ack_pend_q);
        end

        busy_o = (state_q == ST_ADDR_ACK) || (state_q == ST_DATA) || (state_q == ST_DATA_ACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (overflow_set) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr_i) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow_o  = overflow_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2cs_rx_byte_engine.sv
module tb_i2cs_rx_byte_engine;
    import i2cs_pkg::*;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_i;
    logic [6:0] slave_addr_i;
    logic       scl_i;
    logic       sda_m;
    logic       sda_i;
    logic       sda_oe_o;
    logic       fifo_push_o;
    logic [7:0] fifo_wr_data_o;
    logic       fifo_full_i;
    logic       busy_o;
    logic       overflow_o;
    logic       overflow_clr_i;
    logic [2:0] dbg_state_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int push_count   = 0;
    int oe_cycles    = 0;

    logic [7:0] exp_q[$];
    logic       model_ovf = 1'b0;
    logic [7:0] tx_data[4];
    logic       tx_full[4];

    // Open-drain bus: either side pulling low wins.
    assign sda_i = sda_m & ~sda_oe_o;

    i2cs_rx_byte_engine dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable_i),
        .slave_addr_i   (slave_addr_i),
        .scl_i          (scl_i),
        .sda_i          (sda_i),
        .sda_oe_o       (sda_oe_o),
        .fifo_push_o    (fifo_push_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .fifo_full_i    (fifo_full_i),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i),
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (fifo_push_o === 1'b1) begin
            logic [7:0] e;
            push_count++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL push_unexpected: got data %h, required no push", fifo_wr_data_o);
            end else begin
                e = exp_q.pop_front();
                if (fifo_wr_data_o !== e) begin
                    tests_failed++;
                    $display("FAIL push_data: got %h, required %h", fifo_wr_data_o, e);
                end
            end
            tests_run++;
            if (fifo_full_i !== 1'b0) begin
                tests_failed++;
                $display("FAIL push_while_full: got push with fifo_full_i=%b, required none", fifo_full_i);
            end
        end
        if (sda_oe_o === 1'b1) oe_cycles++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_i = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_i = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_i = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_m = b; tick(Q);
        scl_i = 1'b1;
        if (glitch) begin
            tick(3);
            scl_i = 1'b0; tick(2);
            scl_i = 1'b1; tick(2 * Q - 5);
        end else begin
            tick(2 * Q);
        end
        scl_i = 1'b0; tick(Q);
    endtask

    // Sends 8 bits MSB first plus the ACK clock; ack is the slave's SDA pull
    // sampled in the middle of the 9th SCL high phase.
    task automatic send_byte(input logic [7:0] b, input int glitch_idx, output logic ack);
        for (int i = 0; i < 8; i++) send_bit(b[7-i], (i == glitch_idx));
        sda_m = 1'b1; tick(Q);
        scl_i = 1'b1; tick(Q);
        ack = sda_oe_o;
        tick(Q);
        scl_i = 1'b0; tick(Q);
    endtask

    // One full master-write transaction, checked against the spec-level model:
    // address ACKed only for own address with R/W=0; each data byte ACKed and
    // pushed iff addressed and the FIFO is not full, otherwise dropped and
    // overflow set.
    task automatic run_xfer(input string name, input logic [7:0] addr_byte, input int n);
        logic ack;
        logic exp_addr_ack;
        logic exp_ack;
        int   exp_pushes;
        int   push_before;
        exp_addr_ack = (addr_byte[7:1] == slave_addr_i) && (addr_byte[0] == 1'b0);
        exp_pushes   = 0;
        push_before  = push_count;

        i2c_start();
        send_byte(addr_byte, -1, ack);
        tests_run++;
        if (ack !== exp_addr_ack) begin
            tests_failed++;
            $display("FAIL %s addr_ack: got %b, required %b", name, ack, exp_addr_ack);
        end
        tests_run++;
        if (dbg_state_o !== (exp_addr_ack ? 3'(ST_DATA) : 3'(ST_IGNORE))) begin
            tests_failed++;
            $display("FAIL %s state_after_addr: got %0d, required %0d", name, dbg_state_o,
                     exp_addr_ack ? 3'(ST_DATA) : 3'(ST_IGNORE));
        end
        tests_run++;
        if (busy_o !== exp_addr_ack) begin
            tests_failed++;
            $display("FAIL %s busy_in_xfer: got %b, required %b", name, busy_o, exp_addr_ack);
        end

        for (int i = 0; i < n; i++) begin
            fifo_full_i = tx_full[i];
            exp_ack     = exp_addr_ack && !tx_full[i];
            if (exp_addr_ack) begin
                if (tx_full[i]) begin
                    model_ovf = 1'b1;
                end else begin
                    exp_q.push_back(tx_data[i]);
                    exp_pushes++;
                end
            end
            send_byte(tx_data[i], -1, ack);
            fifo_full_i = 1'b0;
            tests_run++;
            if (ack !== exp_ack) begin
                tests_failed++;
                $display("FAIL %s data_ack[%0d]: got %b, required %b", name, i, ack, exp_ack);
            end
        end

        i2c_stop();
        tick(4);
        tests_run++;
        if (busy_o !== 1'b0 || dbg_state_o !== 3'(ST_IDLE)) begin
            tests_failed++;
            $display("FAIL %s after_stop: got busy=%b state=%0d, required busy=0 state=%0d",
                     name, busy_o, dbg_state_o, 3'(ST_IDLE));
        end
        tests_run++;
        if (push_count - push_before != exp_pushes || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s push_count: got %0d (pending %0d), required %0d", name,
                     push_count - push_before, exp_q.size(), exp_pushes);
        end
        tests_run++;
        if (overflow_o !== model_ovf) begin
            tests_failed++;
            $display("FAIL %s overflow: got %b, required %b", name, overflow_o, model_ovf);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; enable_i = 1'b1; slave_addr_i = 7'h42;
        scl_i = 1'b1; sda_m = 1'b1; fifo_full_i = 1'b0; overflow_clr_i = 1'b0;
        tick(3);
        tests_run++;
        if ({sda_oe_o, fifo_push_o, busy_o, overflow_o} !== 4'b0000 || fifo_wr_data_o !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got oe=%b push=%b busy=%b ovf=%b data=%h, required all 0",
                     sda_oe_o, fifo_push_o, busy_o, overflow_o, fifo_wr_data_o);
        end
        tests_run++;
        if (dbg_state_o !== 3'(ST_IDLE)) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d, required %0d", dbg_state_o, 3'(ST_IDLE));
        end
        rst = 1'b0;
        tick(5);
        tests_run++;
        if ({sda_oe_o, fifo_push_o, busy_o, overflow_o} !== 4'b0000 || dbg_state_o !== 3'(ST_IDLE)) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got oe=%b push=%b busy=%b ovf=%b state=%0d, required idle",
                     sda_oe_o, fifo_push_o, busy_o, overflow_o, dbg_state_o);
        end
    endtask

    task automatic test_basic_write();
        slave_addr_i = 7'h42;
        tx_data[0] = 8'h5A; tx_full[0] = 1'b0;
        tx_data[1] = 8'h3C; tx_full[1] = 1'b0;
        run_xfer("basic_write", {7'h42, 1'b0}, 2);
    endtask

    task automatic test_addr_mismatch();
        int oe_before;
        slave_addr_i = 7'h42;
        oe_before = oe_cycles;
        tx_data[0] = 8'hC7; tx_full[0] = 1'b0;
        tx_data[1] = 8'h01; tx_full[1] = 1'b0;
        run_xfer("addr_mismatch", {7'h43, 1'b0}, 2);
        tests_run++;
        if (oe_cycles != oe_before) begin
            tests_failed++;
            $display("FAIL addr_mismatch_sda: got %0d driven cycles, required 0", oe_cycles - oe_before);
        end
    endtask

    task automatic test_fifo_full();
        slave_addr_i = 7'h42;
        tx_data[0] = 8'h77; tx_full[0] = 1'b0;
        tx_data[1] = 8'hA5; tx_full[1] = 1'b1;
        run_xfer("fifo_full", {7'h42, 1'b0}, 2);
        overflow_clr_i = 1'b1; tick(1);
        overflow_clr_i = 1'b0; model_ovf = 1'b0; tick(1);
        tests_run++;
        if (overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_clear: got %b, required 0", overflow_o);
        end
    endtask

    task automatic test_repeated_start();
        logic ack;
        int   push_before;
        slave_addr_i = 7'h42;
        push_before  = push_count;
        i2c_start();
        send_byte({7'h42, 1'b0}, -1, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        i2c_start();
        tests_run++;
        if (dbg_state_o !== 3'(ST_ADDR) || sda_oe_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstart_state: got state=%0d oe=%b, required state=%0d oe=0",
                     dbg_state_o, sda_oe_o, 3'(ST_ADDR));
        end
        send_byte({7'h42, 1'b0}, -1, ack);
        tests_run++;
        if (ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstart_addr_ack: got %b, required 1", ack);
        end
        exp_q.push_back(8'h11);
        send_byte(8'h11, -1, ack);
        i2c_stop();
        tick(4);
        tests_run++;
        if (push_count - push_before != 1 || exp_q.size() != 0 || ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstart_push: got %0d pushes ack=%b, required 1 push ack=1",
                     push_count - push_before, ack);
        end
    endtask

    task automatic test_reset_mid_ack();
        int   push_before;
        logic seen;
        slave_addr_i = 7'h42;
        push_before  = push_count;
        i2c_start();
        for (int i = 0; i < 8; i++) send_bit(tx_bit(8'h84, i), 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 5 * Q && !seen; c++) begin
            if (sda_oe_o === 1'b1) seen = 1'b1;
            else tick(1);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL rst_mid_ack_wait: got no sda_oe_o within %0d cycles, required 1", 5 * Q);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (sda_oe_o !== 1'b0 || dbg_state_o !== 3'(ST_IDLE) || fifo_push_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_ack: got oe=%b state=%0d push=%b busy=%b, required 0/%0d/0/0",
                     sda_oe_o, dbg_state_o, fifo_push_o, busy_o, 3'(ST_IDLE));
        end
        scl_i = 1'b1; tick(2);
        sda_m = 1'b1; tick(2);
        rst = 1'b0; tick(5);
        model_ovf = 1'b0;
        tests_run++;
        if (push_count != push_before || dbg_state_o !== 3'(ST_IDLE)) begin
            tests_failed++;
            $display("FAIL rst_mid_ack_after: got pushes=%0d state=%0d, required 0 and %0d",
                     push_count - push_before, dbg_state_o, 3'(ST_IDLE));
        end
    endtask

    function automatic logic tx_bit(input logic [7:0] b, input int i);
        return b[7-i];
    endfunction

    task automatic test_enable_off();
        logic ack;
        logic seen;
        slave_addr_i = 7'h42;
        i2c_start();
        send_byte({7'h42, 1'b0}, -1, ack);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < 8; i++) send_bit(tx_bit(8'h5A, i), 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 5 * Q && !seen; c++) begin
            if (sda_oe_o === 1'b1) seen = 1'b1;
            else tick(1);
        end
        enable_i = 1'b0;
        tick(2);
        tests_run++;
        if (!seen || sda_oe_o !== 1'b0 || dbg_state_o !== 3'(ST_IDLE) || overflow_o !== model_ovf) begin
            tests_failed++;
            $display("FAIL enable_off: got seen=%b oe=%b state=%0d ovf=%b, required 1/0/%0d/%b",
                     seen, sda_oe_o, dbg_state_o, overflow_o, 3'(ST_IDLE), model_ovf);
        end
        sda_m = 1'b1; tick(Q);
        scl_i = 1'b1; tick(2 * Q);
        scl_i = 1'b0; tick(Q);
        i2c_stop();
        enable_i = 1'b1;
        tick(4);
        tests_run++;
        if (exp_q.size() != 0 || dbg_state_o !== 3'(ST_IDLE)) begin
            tests_failed++;
            $display("FAIL enable_off_push: got pending=%0d state=%0d, required 0 and %0d",
                     exp_q.size(), dbg_state_o, 3'(ST_IDLE));
        end
    endtask

    task automatic test_random();
        logic [7:0] addr_byte;
        int         n;
        for (int t = 0; t < 10; t++) begin
            slave_addr_i = 7'($urandom_range(0, 127));
            case ($urandom_range(0, 3))
                0:       addr_byte = {7'($urandom_range(0, 127)), 1'($urandom_range(0, 1))};
                1:       addr_byte = {slave_addr_i, 1'b1};
                default: addr_byte = {slave_addr_i, 1'b0};
            endcase
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                tx_data[i] = 8'($urandom_range(0, 255));
                tx_full[i] = ($urandom_range(0, 3) == 0);
            end
            run_xfer("random", addr_byte, n);
            if ($urandom_range(0, 2) == 0) begin
                overflow_clr_i = 1'b1; tick(1);
                overflow_clr_i = 1'b0; tick(1);
                model_ovf = 1'b0;
            end
        end
    endtask

`ifdef I2CS_RX_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic ack;
        int   push_before;
        slave_addr_i = 7'h42;
        push_before  = push_count;
        i2c_start();
        send_byte({7'h42, 1'b0}, -1, ack);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 2, ack);
        i2c_stop();
        tick(4);
        tests_run++;
        if (push_count - push_before != 1 || exp_q.size() != 0 || ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch: got %0d pushes ack=%b, required 1 push of c3 ack=1",
                     push_count - push_before, ack);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_write();
        test_addr_mismatch();
        test_fifo_full();
        test_repeated_start();
        test_reset_mid_ack();
        test_enable_off();
        test_random();
`ifdef I2CS_RX_GLITCH_FILTER_EN
        test_glitch();
`endif
        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
